// File: rtl/lzd_norm_pipe_if.sv
// Operand/result bus for lzd_norm_pipe: upstream valid/ready plus
// operand, downstream valid/ready plus the normalised result.
interface lzd_norm_pipe_if #(
  parameter int WIDTH = 37,
  parameter int EXP_W = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [EXP_W-1:0] i_exp;
  logic             o_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_lzd_num;
  logic [WIDTH-1:0] o_norm;
  logic [EXP_W-1:0] o_exp_adj;
  logic             o_zero;
  logic             o_uflow;

  modport slave (
    input  i_valid, i_data, i_exp, i_ready,
    output o_ready, o_valid, o_lzd_num, o_norm, o_exp_adj, o_zero, o_uflow
  );

  modport master (
    output i_valid, i_data, i_exp, i_ready,
    input  o_ready, o_valid, o_lzd_num, o_norm, o_exp_adj, o_zero, o_uflow
  );
endinterface

// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero detect / left-normalise / exponent adjust with
// valid/ready backpressure. Optional denormal clamp: LZD_DENORM_CLAMP_EN.
module lzd_norm_pipe #(
  parameter int WIDTH = 37,
  parameter int EXP_W = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  lzd_norm_pipe_if.slave   bus
);
  localparam int LG = $clog2(WIDTH);
  localparam int P  = 1 << LG;
  localparam int LW = LG + 1;
  localparam int CW = ((CNT_W > EXP_W) ? CNT_W : EXP_W) + 1;

  // Stage-1 LZD tree over the input padded at the LSB end to a power of two
  logic [CNT_W-1:0] w_lzd;
  logic             w_zero;

  always_comb begin : lzd_tree
    logic [P-1:0]         nz;
    logic [P-1:0][LW-1:0] cnt;
    nz  = P'(bus.i_data) << (P - WIDTH);
    cnt = '0;
    for (int l = 1; l <= LG; l++) begin
      for (int i = 0; i < (P >> l); i++) begin
        cnt[i] = nz[2*i+1] ? cnt[2*i+1] : LW'(1 << (l - 1)) + cnt[2*i];
        nz[i]  = nz[2*i+1] | nz[2*i];
      end
    end
    w_zero = ~|bus.i_data;
    w_lzd  = w_zero ? CNT_W'(WIDTH) : CNT_W'(cnt[0]);
  end

  logic             r_s1_v, r_s2_v;
  logic [WIDTH-1:0] r_s1_data;
  logic [EXP_W-1:0] r_s1_exp;
  logic [CNT_W-1:0] r_s1_lzd;
  logic             r_s1_zero;
  logic             w_s1_load, w_s2_load;

  assign bus.o_ready = ~r_s1_v | ~r_s2_v | bus.i_ready;
  assign w_s1_load   = bus.i_valid & bus.o_ready;
  assign w_s2_load   = r_s1_v & (~r_s2_v | bus.i_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_exp  <= '0;
      r_s1_lzd  <= '0;
      r_s1_zero <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_v    <= 1'b1;
        r_s1_data <= bus.i_data;
        r_s1_exp  <= bus.i_exp;
        r_s1_lzd  <= w_lzd;
        r_s1_zero <= w_zero;
      end else if (w_s2_load) begin
        r_s1_v    <= 1'b0;
      end
    end
  end

  // Stage-2 shift / exponent arithmetic
  logic             w_uflow;
  logic [CNT_W-1:0] w_shift;
  logic [EXP_W-1:0] w_exp_adj;
  logic [WIDTH-1:0] w_norm;

  always_comb begin
    w_uflow = ~r_s1_zero & (CW'(r_s1_lzd) >= CW'(r_s1_exp));
`ifdef LZD_DENORM_CLAMP_EN
    w_shift   = w_uflow ? CNT_W'(r_s1_exp) : r_s1_lzd;
    w_exp_adj = w_uflow ? '0 : r_s1_exp - EXP_W'(r_s1_lzd);
`else
    w_shift   = r_s1_lzd;
    w_exp_adj = r_s1_exp - EXP_W'(r_s1_lzd);
`endif
    if (r_s1_zero) w_exp_adj = '0;
    w_norm = r_s1_data << w_shift;
  end

  logic [CNT_W-1:0] r_lzd;
  logic [WIDTH-1:0] r_norm;
  logic [EXP_W-1:0] r_exp_adj;
  logic             r_zero, r_uflow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_v    <= 1'b0;
      r_lzd     <= '0;
      r_norm    <= '0;
      r_exp_adj <= '0;
      r_zero    <= 1'b0;
      r_uflow   <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_v    <= 1'b1;
        r_lzd     <= r_s1_lzd;
        r_norm    <= w_norm;
        r_exp_adj <= w_exp_adj;
        r_zero    <= r_s1_zero;
        r_uflow   <= w_uflow;
      end else if (bus.i_ready) begin
        r_s2_v    <= 1'b0;
      end
    end
  end

  assign bus.o_valid   = r_s2_v;
  assign bus.o_lzd_num = r_lzd;
  assign bus.o_norm    = r_norm;
  assign bus.o_exp_adj = r_exp_adj;
  assign bus.o_zero    = r_zero;
  assign bus.o_uflow   = r_uflow;
endmodule
